// File: rtl/lsq_fwd.sv
// lsq_fwd: load/store queue with out-of-order load issue, store-to-load forwarding
// and in-order committed store drain to a single-port dcache.
module lsq_fwd #(
   parameter int DEPTH = 8,
   parameter int XLEN = 32,
   parameter int TAG_W = 5,
   parameter int REG_W = 5,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dp_valid,
   input  logic             dp_is_store,
   input  logic [TAG_W-1:0] dp_tag,
   input  logic [REG_W-1:0] dp_dest,
   input  logic             dp_unsigned,
   output logic             lsq_full,
   output logic [IW-1:0]    lsq_idx,
   input  logic             ex_valid,
   input  logic [IW-1:0]    ex_idx,
   input  logic [XLEN-1:0]  ex_addr,
   input  logic [XLEN-1:0]  ex_data,
   input  logic [1:0]       ex_size,
   input  logic             commit_valid,
   input  logic             flush,
   output logic             dc_req_valid,
   output logic             dc_req_store,
   output logic [XLEN-1:0]  dc_req_addr,
   output logic [XLEN-1:0]  dc_req_data,
   output logic [1:0]       dc_req_size,
   input  logic             dc_resp_valid,
   input  logic [XLEN-1:0]  dc_resp_data,
   output logic             cdb_valid,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [REG_W-1:0] cdb_dest,
   output logic [XLEN-1:0]  cdb_value,
   output logic             st_done_valid,
   output logic [TAG_W-1:0] st_done_tag
);
   localparam logic [2:0] S_FREE = 3'd0, S_WAIT = 3'd1, S_RDY = 3'd2,
                          S_ISS = 3'd3, S_DONE = 3'd4, S_COM = 3'd5;

   logic [2:0]       st [DEPTH];
   logic [2:0]       st_n [DEPTH];
   logic [DEPTH-1:0] e_st, e_uns;
   logic [TAG_W-1:0] e_tag [DEPTH];
   logic [REG_W-1:0] e_dest [DEPTH];
   logic [XLEN-1:0]  e_addr [DEPTH];
   logic [XLEN-1:0]  e_data [DEPTH];
   logic [1:0]       e_size [DEPTH];
   logic [IW:0]      head, tail, head_n, tail_n, n_com;
   logic [IW-1:0]    h, req_idx, ld_sel, fw_sel, cdb_sel, lq_sel;
   logic             req_kill, alloc, ex_ok, commit_ok, free_head, port_free;
   logic             st_launch, ld_launch, ld_resp, fw_fire, ld_go, fw_go;
   logic [XLEN-1:0]  fw_raw, cdb_raw;

   function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic [1:0] sz,
                                           input logic u);
      return sz == 2'd0 ? {{(XLEN-8){~u & v[7]}}, v[7:0]} :
             sz == 2'd1 ? {{(XLEN-16){~u & v[15]}}, v[15:0]} : v;
   endfunction

   assign h = head[IW-1:0];
   assign lsq_idx = tail[IW-1:0];
   assign lsq_full = (h == tail[IW-1:0]) && (head[IW] != tail[IW]);
   assign alloc = dp_valid && !lsq_full && !flush;
   assign ex_ok = ex_valid && !flush && st[ex_idx] == S_WAIT;
   assign commit_ok = commit_valid && e_st[h] && st[h] == S_RDY;
   assign ld_resp = dc_resp_valid && dc_req_valid && !dc_req_store && !req_kill;
   assign free_head = (dc_resp_valid && dc_req_valid && dc_req_store) || st[h] == S_DONE;
   assign port_free = !dc_req_valid || dc_resp_valid;
   assign st_launch = port_free && st[h] == S_COM && !(dc_req_valid && dc_req_store);
   assign ld_launch = port_free && !st_launch && ld_go && !flush;
   assign lq_sel = st_launch ? h : ld_sel;
   assign fw_fire = fw_go && !ld_resp && !flush;
   assign cdb_sel = ld_resp ? req_idx : fw_sel;
   assign cdb_raw = ld_resp ? dc_resp_data : fw_raw;
   assign head_n = head + {{IW{1'b0}}, free_head};
   assign tail_n = flush ? head_n + n_com : tail + {{IW{1'b0}}, alloc};

   // Walk loads oldest-first; for each, scan its older stores for the youngest word match.
   always_comb begin
      logic [IW-1:0]   ci, cj;
      logic            blk, hit, same;
      logic [XLEN-1:0] hd;
      ld_go = 1'b0;
      ld_sel = '0;
      fw_go = 1'b0;
      fw_sel = '0;
      fw_raw = '0;
      for (int k = 0; k < DEPTH; k++) begin
         ci = h + IW'(k);
         blk = 1'b0;
         hit = 1'b0;
         same = 1'b0;
         hd = '0;
         for (int m = 0; m < DEPTH; m++) begin
            cj = h + IW'(m);
            if (m < k && e_st[cj] && st[cj] != S_FREE) begin
               if (st[cj] == S_WAIT)
                  blk = 1'b1;
               else if (e_addr[cj][XLEN-1:2] == e_addr[ci][XLEN-1:2]) begin
                  hit = 1'b1;
                  same = e_addr[cj] == e_addr[ci] && e_size[cj] == e_size[ci];
                  hd = e_data[cj];
               end
            end
         end
         if (st[ci] == S_RDY && !e_st[ci] && !blk) begin
            if (!hit && !ld_go) begin
               ld_go = 1'b1;
               ld_sel = ci;
            end
            if (hit && same && !fw_go) begin
               fw_go = 1'b1;
               fw_sel = ci;
               fw_raw = hd;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) st_n[i] = st[i];
      if (alloc) st_n[lsq_idx] = S_WAIT;
      if (ex_ok) st_n[ex_idx] = S_RDY;
      if (ld_launch) st_n[ld_sel] = S_ISS;
      if (fw_fire) st_n[fw_sel] = S_DONE;
      if (ld_resp) st_n[req_idx] = S_DONE;
      if (commit_ok) st_n[h] = S_COM;
      if (free_head) st_n[h] = S_FREE;
      n_com = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n_com = n_com + {{IW{1'b0}}, st_n[i] == S_COM};
         if (flush && st_n[i] != S_COM) st_n[i] = S_FREE;
      end
   end

   always_ff @(posedge clock) begin
      if (alloc) begin
         e_st[lsq_idx] <= dp_is_store;
         e_uns[lsq_idx] <= dp_unsigned;
         e_tag[lsq_idx] <= dp_tag;
         e_dest[lsq_idx] <= dp_dest;
      end
      if (ex_ok) begin
         e_addr[ex_idx] <= ex_addr;
         e_data[ex_idx] <= ex_data;
         e_size[ex_idx] <= ex_size;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         for (int i = 0; i < DEPTH; i++) st[i] <= S_FREE;
         dc_req_valid <= 1'b0;
         dc_req_store <= 1'b0;
         dc_req_addr <= '0;
         dc_req_data <= '0;
         dc_req_size <= '0;
         req_idx <= '0;
         req_kill <= 1'b0;
         cdb_valid <= 1'b0;
         cdb_tag <= '0;
         cdb_dest <= '0;
         cdb_value <= '0;
         st_done_valid <= 1'b0;
         st_done_tag <= '0;
      end else begin
         head <= head_n;
         tail <= tail_n;
         for (int i = 0; i < DEPTH; i++) st[i] <= st_n[i];
         if (st_launch || ld_launch) begin
            dc_req_valid <= 1'b1;
            dc_req_store <= st_launch;
            dc_req_addr <= e_addr[lq_sel];
            dc_req_data <= e_data[lq_sel];
            dc_req_size <= e_size[lq_sel];
            req_idx <= lq_sel;
            req_kill <= 1'b0;
         end else if (dc_resp_valid) begin
            dc_req_valid <= 1'b0;
            req_kill <= 1'b0;
         end else if (flush && dc_req_valid && !dc_req_store)
            req_kill <= 1'b1;
         cdb_valid <= (ld_resp || fw_fire) && !flush;
         if (ld_resp || fw_fire) begin
            cdb_tag <= e_tag[cdb_sel];
            cdb_dest <= e_dest[cdb_sel];
            cdb_value <= ext(cdb_raw, e_size[cdb_sel], e_uns[cdb_sel]);
         end
         st_done_valid <= ex_ok && e_st[ex_idx];
         if (ex_ok) st_done_tag <= e_tag[ex_idx];
      end
   end
endmodule
